ht_ptg_rmw: RTL

HT_PTG_RMW -- requirements
Module: ht_ptg_rmw

---
 rtl/hash_table_pkg.sv | 33 +++
 rtl/ht_ptg_modify.sv | 54 +++++
 rtl/ht_ptg_rmw.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/hash_table_pkg.sv
//============================================================================
// hash_table_pkg
// Shared types for the hash-table PTG blocks: entry layout, ASID, ops.
// Revision: 1.0
//============================================================================
`default_nettype none

package hash_table_pkg;

  localparam int ASID_W    = 8;
  localparam int PAYLOAD_W = 16;

  typedef logic [ASID_W-1:0] asid_t;

  typedef struct packed {
    logic                 v;
    asid_t                asid;
    logic [PAYLOAD_W-1:0] payload;
  } ptge_t;

  localparam logic INV   = 1'b0;
  localparam logic VALID = 1'b1;

  typedef enum logic [1:0] {
    OP_WRITE    = 2'd0,
    OP_INV_ONE  = 2'd1,
    OP_INV_ASID = 2'd2,
    OP_INV_ALL  = 2'd3
  } op_e;

endpackage

`default_nettype wire

// File: rtl/ht_ptg_modify.sv
//============================================================================
// ht_ptg_modify
// Combinational group update: per-entry write/match/invalidate and a count
// of entries that went from valid to invalid.
// Revision: 1.0
//============================================================================
`default_nettype none

module ht_ptg_modify
  import hash_table_pkg::*;
#(
  parameter  int NENT  = 8,
  localparam int IDX_W = $clog2(NENT),
  localparam int CNT_W = $clog2(NENT + 1)
) (
  input  ptge_t [NENT-1:0] src,
  input  op_e              op,
  input  logic [IDX_W-1:0] idx,
  input  ptge_t            dat,
  input  asid_t            asid,
  output ptge_t [NENT-1:0] dst,
  output logic             changed,
  output logic [CNT_W-1:0] inv_count
);

  logic             w_hit;
  logic [CNT_W-1:0] w_cnt;

  always_comb begin
    dst   = src;
    w_cnt = '0;
    w_hit = 1'b0;
    for (int i = 0; i < NENT; i++) begin
      w_hit = 1'b0;
      unique case (op)
        OP_WRITE:    if (IDX_W'(i) == idx) dst[i] = dat;
        OP_INV_ONE:  w_hit = (IDX_W'(i) == idx) && (src[i].v == VALID) && (src[i].asid == asid);
        OP_INV_ASID: w_hit = (src[i].v == VALID) && (src[i].asid == asid);
        OP_INV_ALL:  w_hit = (src[i].v == VALID);
        default:     w_hit = 1'b0;
      endcase
      // Only valid entries can hit, so every hit is a valid->invalid transition.
      if (w_hit) begin
        dst[i].v = INV;
        w_cnt    = w_cnt + CNT_W'(1);
      end
    end
    changed   = (op == OP_WRITE) ? 1'b1 : (w_cnt != '0);
    inv_count = w_cnt;
  end

endmodule

`default_nettype wire

// File: rtl/ht_ptg_rmw.sv
//============================================================================
// ht_ptg_rmw
// Read-modify-write engine for one PTG row; optional last-written-row bypass
// enabled by macro HT_PTG_RMW_BYPASS_EN.
// Revision: 1.0
//============================================================================
`default_nettype none

module ht_ptg_rmw
  import hash_table_pkg::*;
#(
  parameter  int NENT     = 8,
  parameter  int GRP_BITS = 10,
  parameter  int RD_LAT   = 1,
  localparam int IDX_W    = $clog2(NENT),
  localparam int CNT_W    = $clog2(NENT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [GRP_BITS-1:0] req_grp,
  input  logic [IDX_W-1:0]    req_idx,
  input  ptge_t               req_dat,
  input  asid_t               req_asid,
  input  logic                byp_flush,
  output logic                ena,
  output logic                wea,
  output logic [GRP_BITS-1:0] addra,
  input  ptge_t [NENT-1:0]    douta,
  output ptge_t [NENT-1:0]    dina,
  output logic                done,
  output logic                changed,
  output logic [CNT_W-1:0]    inv_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_WAIT   = 3'd2,
    S_MODIFY = 3'd3,
    S_WRITE  = 3'd4
  } state_t;

  localparam logic [1:0] c_wait_init = 2'(RD_LAT > 1 ? RD_LAT - 2 : 0);

  state_t              r_state;
  op_e                 r_op;
  logic [IDX_W-1:0]    r_idx;
  ptge_t               r_dat;
  asid_t               r_asid;
  logic [1:0]          r_wait_cnt;
  logic                r_ena;
  logic                r_wea;
  logic [GRP_BITS-1:0] r_addra;
  ptge_t [NENT-1:0]    r_dina;
  logic                r_done;
  logic                r_changed;
  logic [CNT_W-1:0]    r_inv_count;

  logic                w_byp_hit;
  ptge_t [NENT-1:0]    w_src;
  ptge_t [NENT-1:0]    w_dst;
  logic                w_changed;
  logic [CNT_W-1:0]    w_inv_count;

  assign req_ready = (r_state == S_IDLE) && !rst;
  assign ena       = r_ena;
  assign wea       = r_wea;
  assign addra     = r_addra;
  assign dina      = r_dina;
  assign done      = r_done;
  assign changed   = r_changed;
  assign inv_count = r_inv_count;

`ifdef HT_PTG_RMW_BYPASS_EN
  logic                r_byp_vld;
  logic                r_use_byp;
  logic [GRP_BITS-1:0] r_byp_grp;
  ptge_t [NENT-1:0]    r_byp_row;

  // A flush in the accept cycle means the table may be newer than our copy.
  assign w_byp_hit = r_byp_vld && !byp_flush && (req_grp == r_byp_grp);
  assign w_src     = r_use_byp ? r_byp_row : douta;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_byp_vld <= 1'b0;
      r_use_byp <= 1'b0;
      r_byp_grp <= '0;
      r_byp_row <= '0;
    end else begin
      if (req_ready && req_valid) r_use_byp <= w_byp_hit;
      if (byp_flush) begin
        r_byp_vld <= 1'b0;
      end else if ((r_state == S_WRITE) && r_wea) begin
        r_byp_vld <= 1'b1;
        r_byp_grp <= r_addra;
        r_byp_row <= r_dina;
      end
    end
  end
`else
  logic w_unused_flush;
  assign w_unused_flush = byp_flush;
  assign w_byp_hit      = 1'b0;
  assign w_src          = douta;
`endif

  ht_ptg_modify #(.NENT(NENT)) u_modify (
    .src       (w_src),
    .op        (r_op),
    .idx       (r_idx),
    .dat       (r_dat),
    .asid      (r_asid),
    .dst       (w_dst),
    .changed   (w_changed),
    .inv_count (w_inv_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_WRITE;
      r_idx       <= '0;
      r_dat       <= '0;
      r_asid      <= '0;
      r_wait_cnt  <= '0;
      r_ena       <= 1'b0;
      r_wea       <= 1'b0;
      r_addra     <= '0;
      r_dina      <= '0;
      r_done      <= 1'b0;
      r_changed   <= 1'b0;
      r_inv_count <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op    <= op_e'(req_op);
            r_idx   <= req_idx;
            r_dat   <= req_dat;
            r_asid  <= req_asid;
            r_addra <= req_grp;
            if (w_byp_hit) begin
              r_state <= S_MODIFY;
            end else begin
              r_state <= S_READ;
              r_ena   <= 1'b1;
              r_wea   <= 1'b0;
            end
          end
        end
        S_READ: begin
          r_ena <= 1'b0;
          if (RD_LAT > 1) begin
            r_state    <= S_WAIT;
            r_wait_cnt <= c_wait_init;
          end else begin
            r_state <= S_MODIFY;
          end
        end
        S_WAIT: begin
          if (r_wait_cnt == 2'd0) r_state <= S_MODIFY;
          else                    r_wait_cnt <= r_wait_cnt - 2'd1;
        end
        S_MODIFY: begin
          // Results and write strobes are registered together so they line up with done.
          r_dina      <= w_dst;
          r_changed   <= w_changed;
          r_inv_count <= w_inv_count;
          r_done      <= 1'b1;
          r_ena       <= w_changed;
          r_wea       <= w_changed;
          r_state     <= S_WRITE;
        end
        S_WRITE: begin
          r_done  <= 1'b0;
          r_ena   <= 1'b0;
          r_wea   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
